// File: rtl/atom_ps2_keyboard.sv
// PS/2 keyboard receiver and scan-code decoder that drives the Acorn ATOM 10x6 key matrix
// onto 8255 PPI Port B and Port C bit 6.
module atom_ps2_keyboard #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic [3:0] i_row,
    output logic [7:0] o_port_b,
    output logic       o_rept_n,
    output logic       o_break_pulse,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;
    typedef enum logic [2:0] {K_NONE, K_MATRIX, K_SHIFT, K_CTRL, K_REPT, K_BREAK} key_kind_t;

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic                  r_clk_filt;
    logic                  r_fall;
    logic                  w_data;

    assign w_data = r_data_sync[1];

    // The filtered clock only moves once the whole history window agrees.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_hist  <= '1;
            r_clk_filt  <= 1'b1;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_hist  <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
            r_fall      <= 1'b0;
            if (&r_clk_hist) begin
                r_clk_filt <= 1'b1;
            end else if (~|r_clk_hist) begin
                r_clk_filt <= 1'b0;
                r_fall     <= r_clk_filt;
            end
        end
    end

    rx_state_t     r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_rx_byte;
    logic          r_parity_ok;
    logic [TW-1:0] r_timeout;
    logic          r_byte_valid;
    logic          r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_rx_byte    <= '0;
            r_parity_ok  <= 1'b0;
            r_timeout    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_fall) begin
                r_timeout <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!w_data) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_rx_byte <= {w_data, r_rx_byte[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity_ok <= ^{r_rx_byte, w_data};
                        r_state     <= S_STOP;
                    end
                    default: begin
                        if (w_data && r_parity_ok) r_byte_valid <= 1'b1;
                        else                       r_frame_err  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                // A stalled frame is dropped so the next start bit resynchronises.
                if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_state     <= S_IDLE;
                    r_frame_err <= 1'b1;
                    r_timeout   <= '0;
                end else begin
                    r_timeout <= r_timeout + 1'b1;
                end
            end else begin
                r_timeout <= '0;
            end
        end
    end

    logic      r_ext;
    key_kind_t w_kind;
    logic [3:0] w_row;
    logic [2:0] w_col;

    always_comb begin
        w_kind = K_NONE;
        w_row  = 4'd0;
        w_col  = 3'd0;
        if (r_ext) begin
            if (r_rx_byte == 8'h5A) begin
                w_kind = K_MATRIX; w_row = 4'd6; w_col = 3'd1;
            end
        end else begin
            case (r_rx_byte)
                8'h1C: begin w_kind = K_MATRIX; w_row = 4'd3; w_col = 3'd5; end
                8'h32: begin w_kind = K_MATRIX; w_row = 4'd2; w_col = 3'd5; end
                8'h29: begin w_kind = K_MATRIX; w_row = 4'd9; w_col = 3'd0; end
                8'h5A: begin w_kind = K_MATRIX; w_row = 4'd6; w_col = 3'd1; end
                8'h66: begin w_kind = K_MATRIX; w_row = 4'd4; w_col = 3'd1; end
                8'h16: begin w_kind = K_MATRIX; w_row = 4'd6; w_col = 3'd3; end
                8'h12, 8'h59: w_kind = K_SHIFT;
                8'h14: w_kind = K_CTRL;
                8'h11: w_kind = K_REPT;
                8'h07: w_kind = K_BREAK;
                default: w_kind = K_NONE;
            endcase
        end
    end

    logic            r_rel;
    logic [9:0][5:0] r_matrix;
    logic            r_shift_mod;
    logic            r_ctrl;
    logic            r_rept;
    logic            r_break;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the key matrix is a small register file, cleared by reset so no key reads as held.
            r_matrix    <= '0;
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_shift_mod <= 1'b0;
            r_ctrl      <= 1'b0;
            r_rept      <= 1'b0;
            r_break     <= 1'b0;
        end else begin
            r_break <= 1'b0;
            if (r_frame_err) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (r_byte_valid) begin
                if (r_rx_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_rx_byte == 8'hF0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                    case (w_kind)
                        K_MATRIX: r_matrix[w_row][w_col] <= !r_rel;
                        K_SHIFT:  r_shift_mod <= !r_rel;
                        K_CTRL:   r_ctrl      <= !r_rel;
                        K_REPT:   r_rept      <= !r_rel;
                        K_BREAK:  r_break     <= !r_rel;
                        default:  ;
                    endcase
                end
            end
        end
    end

    logic [5:0] w_cols;

    always_comb begin
        w_cols = 6'h3F;
        if (i_row < 4'd10) w_cols = ~r_matrix[i_row];
    end

    assign o_port_b      = {~r_shift_mod, ~r_ctrl, w_cols};
    assign o_rept_n      = ~r_rept;
    assign o_break_pulse = r_break;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_atom_ps2_keyboard.sv
// Scoreboard bench for atom_ps2_keyboard: a key-state model predicts Port B / REPT snapshots
// and BREAK / frame-error pulses; a monitor compares them as the DUT presents them.
module tb_atom_ps2_keyboard;

    localparam int TIMEOUT_CYCLES = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] row;
    logic [7:0] port_b;
    logic       rept_n;
    logic       break_pulse;
    logic       frame_err;

    always #5 clk = ~clk;

    atom_ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_ps2_clk     (ps2_clk),
        .i_ps2_data    (ps2_data),
        .i_row         (row),
        .o_port_b      (port_b),
        .o_rept_n      (rept_n),
        .o_break_pulse (break_pulse),
        .o_frame_err   (frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic [3:0] row;
        logic [7:0] port_b;
        logic       rept_n;
    } snap_t;

    snap_t      snap_q[$];
    logic [1:0] evt_q[$];      // {break_pulse, frame_err}
    logic       sample_req = 1'b0;

    // Reference model: key state held as plain bits, indexed row*6+col.
    bit [59:0] m_keys;
    bit m_shift, m_ctrl, m_rept, m_ext, m_rel;

    function automatic int key_id(bit ext, bit [7:0] code);
        if (ext) return (code == 8'h5A) ? 6*6 + 1 : -1;
        case (code)
            8'h1C: return 3*6 + 5;
            8'h32: return 2*6 + 5;
            8'h29: return 9*6 + 0;
            8'h5A: return 6*6 + 1;
            8'h66: return 4*6 + 1;
            8'h16: return 6*6 + 3;
            8'h12, 8'h59: return 100;
            8'h14: return 101;
            8'h11: return 102;
            8'h07: return 103;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] exp_port_b(logic [3:0] r);
        int v = 255;
        if (m_shift) v -= 128;
        if (m_ctrl)  v -= 64;
        if (r < 10)
            for (int c = 0; c < 6; c++)
                if (m_keys[r*6 + c]) v -= (1 << c);
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_keys = '0; m_shift = 0; m_ctrl = 0; m_rept = 0; m_ext = 0; m_rel = 0;
    endtask

    task automatic model_byte(bit [7:0] code);
        int id;
        if (code == 8'hE0) m_ext = 1;
        else if (code == 8'hF0) m_rel = 1;
        else begin
            id = key_id(m_ext, code);
            if (id >= 0 && id < 60) m_keys[id] = !m_rel;
            else if (id == 100) m_shift = !m_rel;
            else if (id == 101) m_ctrl = !m_rel;
            else if (id == 102) m_rept = !m_rel;
            else if (id == 103 && !m_rel) evt_q.push_back(2'b10);
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    task automatic model_err();
        m_ext = 0;
        m_rel = 0;
        evt_q.push_back(2'b01);
    endtask

    task automatic ps2_bit(bit b);
        ps2_data = b;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(bit [7:0] code, bit bad_par = 0, bit bad_stop = 0);
        if (bad_par || bad_stop) model_err();
        else model_byte(code);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(~(^code) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic sweep();
        for (int r = 0; r < 16; r++) begin
            @(posedge clk);
            #1;
            row = 4'(r);
            snap_q.push_back('{row: 4'(r), port_b: exp_port_b(4'(r)), rept_n: !m_rept});
            sample_req = 1'b1;
        end
        @(posedge clk);
        #1 sample_req = 1'b0;
    endtask

    always @(negedge clk) begin
        snap_t s;
        logic [1:0] got;
        if (sample_req) begin
            if (snap_q.size() == 0) begin
                check("snap_q_underflow", 32'd1, 32'd0);
            end else begin
                s = snap_q.pop_front();
                check($sformatf("port_b row%0d", s.row), {24'd0, port_b}, {24'd0, s.port_b});
                check($sformatf("rept_n row%0d", s.row), {31'd0, rept_n}, {31'd0, s.rept_n});
            end
        end
        if (break_pulse || frame_err) begin
            got = {break_pulse, frame_err};
            if (evt_q.size() == 0) check("unexpected_pulse", {30'd0, got}, 32'd0);
            else check("pulse_kind", {30'd0, got}, {30'd0, evt_q.pop_front()});
        end
    end

    initial begin
        bit [7:0] codes[14] = '{8'h1C, 8'h32, 8'h29, 8'h5A, 8'h66, 8'h16, 8'h12,
                                8'h59, 8'h14, 8'h11, 8'h07, 8'hE0, 8'hF0, 8'h55};
        bit [7:0] code;
        int       k, e, n;

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; row = 4'd0;
        model_reset();
        repeat (5) @(posedge clk);
        sweep();
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Single key make then break
        send_frame(8'h1C); sweep();
        send_frame(8'hF0); send_frame(8'h1C); sweep();

        // Modifiers; either shift key releases the shared SHIFT bit
        send_frame(8'h12); send_frame(8'h14); sweep();
        send_frame(8'hF0); send_frame(8'h59); sweep();
        send_frame(8'hF0); send_frame(8'h14); sweep();

        // Parity error leaves the matrix alone
        send_frame(8'h29, 1'b1); sweep();
        send_frame(8'h29); sweep();

        // Stalled frame is aborted by the timeout
        model_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        n = 0;
        while (evt_q.size() != 0 && n < TIMEOUT_CYCLES + 800) begin
            @(posedge clk);
            n++;
        end
        check("timeout_frame_err", 32'(evt_q.size()), 32'd0);
        send_frame(8'h11); sweep();
        send_frame(8'hF0); send_frame(8'h11); sweep();

        // Extended RETURN, BREAK make pulses, BREAK release does not
        send_frame(8'hE0); send_frame(8'h5A); sweep();
        send_frame(8'h07); sweep();
        send_frame(8'hF0); send_frame(8'h07); sweep();

        // Randomised traffic including occasional bad frames
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 14);
            code = (k == 14) ? 8'($urandom_range(0, 255)) : codes[k];
            e = $urandom_range(0, 9);
            send_frame(code, e == 0, e == 1);
            if (t % 2 == 1) sweep();
        end
        sweep();

        // Reset in the middle of a frame while keys are held
        send_frame(8'h1C); send_frame(8'h11);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b0;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        sweep();
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        send_frame(8'h32); sweep();

        repeat (20) @(posedge clk);
        check("evt_q_drained", 32'(evt_q.size()), 32'd0);
        check("snap_q_drained", 32'(snap_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
